shift_ex_stage: RTL

- Execute-stage front end for the 16-bit combinational shifter (ports In/Cnt/Op/Out).
- Accepts decoded shift micro-ops from decode over a valid/ready handshake.
- Resolves the shift count from the register or immediate field, and maps ISA shift functions (including rotate-right) onto the shifter's four ops.
- Registers the result toward the memory/writeback stage, with a one-entry skid buffer so in_ready never depends combinationally on out_ready.

---
 rtl/shift_pkg.sv | 25 ++
 rtl/shift_func_map.sv | 50 +++++
 rtl/shift_ex_stage.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift execute stage: ISA function codes,
// shifter op codes and default datapath widths.
package shift_pkg;

    localparam int DW_DEF = 16;
    localparam int CW_DEF = 4;

    // ISA shift functions as decoded; 101-111 are illegal
    typedef enum logic [2:0] {
        FN_ROL = 3'b000,
        FN_SLL = 3'b001,
        FN_SRA = 3'b010,
        FN_SRL = 3'b011,
        FN_ROR = 3'b100
    } shift_func_e;

    // Native operations of the combinational shifter
    typedef enum logic [1:0] {
        OP_ROTL  = 2'b00,
        OP_SHFL  = 2'b01,
        OP_SHFRA = 2'b10,
        OP_SHFRL = 2'b11
    } shift_op_e;

endpackage

// File: rtl/shift_func_map.sv
// Combinational translation of an ISA shift function plus resolved count
// into the shifter's op/count pair. Rotate-right has no native op, so it
// is expressed as a rotate-left by the complementary count.
module shift_func_map
    import shift_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic [2:0]    func,
    input  logic [CW-1:0] cnt,
    output logic [1:0]    sh_op,
    output logic [CW-1:0] sh_cnt,
    output logic          illegal
);

    // Illegal codes fall back to a harmless shift-left by zero
    always_comb begin
        sh_op   = OP_SHFL;
        sh_cnt  = '0;
        illegal = 1'b0;
        case (func)
            FN_ROL: begin
                sh_op  = OP_ROTL;
                sh_cnt = cnt;
            end
            FN_SLL: begin
                sh_op  = OP_SHFL;
                sh_cnt = cnt;
            end
            FN_SRA: begin
                sh_op  = OP_SHFRA;
                sh_cnt = cnt;
            end
            FN_SRL: begin
                sh_op  = OP_SHFRL;
                sh_cnt = cnt;
            end
            FN_ROR: begin
                // DW is a power of two, so (DW - cnt) mod DW is the
                // CW-bit two's complement of cnt; ROR by 0 stays 0.
                sh_op  = OP_ROTL;
                sh_cnt = -cnt;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/shift_ex_stage.sv
// Execute-stage front end for the 16-bit combinational shifter.
// Accepts shift micro-ops over valid/ready, resolves the count, drives the
// external shifter and registers the result with a one-entry skid buffer so
// in_ready never depends combinationally on out_ready.
// Optional: define SHIFT_ZFLAG_EN to add a registered out_zero flag.
module shift_ex_stage
    import shift_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [DW-1:0] in_rcnt,
    input  logic [CW-1:0] in_icnt,
    input  logic          in_cnt_sel,
    input  logic [2:0]    in_func,
    input  logic [2:0]    in_tag,
    output logic [DW-1:0] sh_in,
    output logic [CW-1:0] sh_cnt,
    output logic [1:0]    sh_op,
    input  logic [DW-1:0] sh_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [2:0]    out_tag,
`ifdef SHIFT_ZFLAG_EN
    output logic          out_zero,
`endif
    output logic          out_err
);

    // Skid buffer: holds the raw op that arrived while the output was stalled
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_data_q,  skid_data_d;
    logic [CW-1:0] skid_cnt_q,   skid_cnt_d;
    logic [2:0]    skid_func_q,  skid_func_d;
    logic [2:0]    skid_tag_q,   skid_tag_d;

    // Output register toward memory/writeback
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q,  out_data_d;
    logic [2:0]    out_tag_q,   out_tag_d;
    logic          out_err_q,   out_err_d;
`ifdef SHIFT_ZFLAG_EN
    logic          out_zero_q,  out_zero_d;
`endif

    logic          accept;
    logic          slot_free;
    logic [CW-1:0] live_cnt;
    logic [DW-1:0] src_data;
    logic [CW-1:0] src_cnt;
    logic [2:0]    src_func;
    logic [2:0]    src_tag;
    logic          src_illegal;
    logic [DW-1:0] result;
    logic          rcnt_unused;

    // Only the low CW bits of the register count are meaningful
    assign live_cnt    = in_cnt_sel ? in_icnt : in_rcnt[CW-1:0];
    assign rcnt_unused = ^in_rcnt[DW-1:CW];

    // Ready comes from reset and the skid flop only
    assign in_ready  = rst & ~skid_valid_q;
    assign accept    = in_valid & in_ready;
    assign slot_free = ~out_valid_q | out_ready;

    // The skid entry is older than anything on the input, so it wins the shifter
    assign src_data = skid_valid_q ? skid_data_q : in_data;
    assign src_cnt  = skid_valid_q ? skid_cnt_q  : live_cnt;
    assign src_func = skid_valid_q ? skid_func_q : in_func;
    assign src_tag  = skid_valid_q ? skid_tag_q  : in_tag;

    shift_func_map #(
        .CW (CW)
    ) u_func_map (
        .func    (src_func),
        .cnt     (src_cnt),
        .sh_op   (sh_op),
        .sh_cnt  (sh_cnt),
        .illegal (src_illegal)
    );

    assign sh_in  = src_data;
    assign result = src_illegal ? '0 : sh_out;

    // Next-state: flush, drain skid, direct load, stall into skid, or go idle
    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_cnt_d   = skid_cnt_q;
        skid_func_d  = skid_func_q;
        skid_tag_d   = skid_tag_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_tag_d    = out_tag_q;
        out_err_d    = out_err_q;
`ifdef SHIFT_ZFLAG_EN
        out_zero_d   = out_zero_q;
`endif
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (slot_free && skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = result;
            out_tag_d    = src_tag;
            out_err_d    = src_illegal;
`ifdef SHIFT_ZFLAG_EN
            out_zero_d   = ~src_illegal && (result == '0);
`endif
            skid_valid_d = 1'b0;
        end else if (slot_free && accept) begin
            out_valid_d  = 1'b1;
            out_data_d   = result;
            out_tag_d    = src_tag;
            out_err_d    = src_illegal;
`ifdef SHIFT_ZFLAG_EN
            out_zero_d   = ~src_illegal && (result == '0);
`endif
        end else if (!slot_free && accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_cnt_d   = live_cnt;
            skid_func_d  = in_func;
            skid_tag_d   = in_tag;
        end else if (slot_free) begin
            out_valid_d  = 1'b0;
        end
    end

    // State registers; reset empties the stage and clears every data flop
    always_ff @(posedge clk) begin
        if (!rst) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_cnt_q   <= '0;
            skid_func_q  <= '0;
            skid_tag_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tag_q    <= '0;
            out_err_q    <= 1'b0;
`ifdef SHIFT_ZFLAG_EN
            out_zero_q   <= 1'b0;
`endif
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_cnt_q   <= skid_cnt_d;
            skid_func_q  <= skid_func_d;
            skid_tag_q   <= skid_tag_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_tag_q    <= out_tag_d;
            out_err_q    <= out_err_d;
`ifdef SHIFT_ZFLAG_EN
            out_zero_q   <= out_zero_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_err   = out_err_q;
`ifdef SHIFT_ZFLAG_EN
    assign out_zero  = out_zero_q;
`endif

endmodule
